// File: rtl/board_render_ctrl_if.sv
// Move-request handshake between the game logic (master) and board_render_ctrl (slave).
interface board_render_ctrl_if;
  logic       mv_valid;
  logic [3:0] mv_cell;
  logic       mv_ready;
  logic       mv_err;

  modport master (output mv_valid, output mv_cell, input mv_ready, input mv_err);
  modport slave  (input mv_valid, input mv_cell, output mv_ready, output mv_err);
endinterface

// File: rtl/board_render_ctrl.sv
// Tic-tac-toe board state plus a 2-stage pixel pipeline that drives the 80x80 shape ROMs.
// Optional macro CURSOR_HILITE_EN adds cursor_cell_i and inverts the highlighted cell.
module board_render_ctrl #(
  parameter int BOARD_X0 = 200,
  parameter int BOARD_Y0 = 120
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           pix_x_i,
  input  logic [9:0]           pix_y_i,
  input  logic                 pix_valid_i,
  input  logic                 frame_start_i,
  input  logic                 game_clr_i,
  board_render_ctrl_if.slave   mv,
  output logic [1:0]           rom_sel_o,
  output logic [6:0]           rom_row_o,
  input  logic [79:0]          rom_data_i,
  output logic                 pix_on_o,
  output logic                 pix_out_valid_o,
  output logic                 turn_o,
  output logic [17:0]          board_o
`ifdef CURSOR_HILITE_EN
  ,
  input  logic [3:0]           cursor_cell_i
`endif
);

  // Cell size is tied to the ROM geometry, so it is not overridable.
  localparam int CELL = 80;

  localparam logic [9:0] X_LO = 10'(BOARD_X0);
  localparam logic [9:0] X_HI = 10'(BOARD_X0 + 3 * CELL);
  localparam logic [9:0] Y_LO = 10'(BOARD_Y0);
  localparam logic [9:0] Y_HI = 10'(BOARD_Y0 + 3 * CELL);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [1:0] CODE_EMPTY = 2'b00;
  localparam logic [1:0] CODE_X     = 2'b01;
  localparam logic [1:0] CODE_O     = 2'b10;
  localparam logic [1:0] SEL_NONE   = 2'b11;

  function automatic logic [1:0] seg_idx(input logic [9:0] d);
    if (d < 10'(CELL))
      return 2'd0;
    else if (d < 10'(2 * CELL))
      return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [6:0] seg_off(input logic [9:0] d, input logic [1:0] idx);
    logic [9:0] base;
    case (idx)
      2'd0:    base = 10'd0;
      2'd1:    base = 10'(CELL);
      default: base = 10'(2 * CELL);
    endcase
    return 7'(d - base);
  endfunction

  function automatic logic [1:0] cell_code(input logic [17:0] b, input logic [3:0] c);
    logic [1:0] code;
    code = CODE_EMPTY;
    for (int n = 0; n < 9; n++)
      if (c == 4'(n))
        code = b[2*n +: 2];
    return code;
  endfunction

  // ---------------------------------------------------------------- move FSM
  logic [1:0]  state_q, state_d;
  logic [3:0]  pcell_q, pcell_d;
  logic [17:0] board_q, board_d;
  logic        turn_q, turn_d;
  logic        err_q, err_d;
  logic        clr_now;

  assign clr_now = frame_start_i && game_clr_i;

  always_comb begin
    state_d = state_q;
    pcell_d = pcell_q;
    board_d = board_q;
    turn_d  = turn_q;
    err_d   = 1'b0;
    if (clr_now) begin
      // Clearing wins over any pending or committing move and never reports an error.
      board_d = '0;
      turn_d  = 1'b0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mv.mv_valid) begin
            if (mv.mv_cell > 4'd8 || cell_code(board_q, mv.mv_cell) != CODE_EMPTY) begin
              err_d = 1'b1;
            end else begin
              pcell_d = mv.mv_cell;
              state_d = ST_PEND;
            end
          end
        end
        ST_PEND: begin
          if (frame_start_i)
            state_d = ST_COMMIT;
        end
        ST_COMMIT: begin
          for (int n = 0; n < 9; n++)
            if (pcell_q == 4'(n))
              board_d[2*n +: 2] = turn_q ? CODE_O : CODE_X;
          turn_d  = ~turn_q;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pcell_q <= '0;
      board_q <= '0;
      turn_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcell_q <= pcell_d;
      board_q <= board_d;
      turn_q  <= turn_d;
      err_q   <= err_d;
    end
  end

  assign mv.mv_ready = (state_q == ST_IDLE);
  assign mv.mv_err   = err_q;
  assign board_o     = board_q;
  assign turn_o      = turn_q;

  // ---------------------------------------------------------------- stage 1: locate pixel
  logic [9:0] dx_p0, dy_p0;
  logic       inb_p1_d, inb_p1_q;
  logic [1:0] col_p1_d, col_p1_q;
  logic [1:0] row_p1_d, row_p1_q;
  logic [6:0] offx_p1_d, offx_p1_q;
  logic [6:0] offy_p1_d, offy_p1_q;
  logic       vld_p1_q;
  logic [3:0] cell_p1;

  assign dx_p0 = pix_x_i - X_LO;
  assign dy_p0 = pix_y_i - Y_LO;

  always_comb begin
    inb_p1_d  = pix_valid_i &&
                pix_x_i >= X_LO && pix_x_i < X_HI &&
                pix_y_i >= Y_LO && pix_y_i < Y_HI;
    col_p1_d  = 2'd0;
    row_p1_d  = 2'd0;
    offx_p1_d = 7'd0;
    offy_p1_d = 7'd0;
    // Outside the board the position registers are parked at zero.
    if (inb_p1_d) begin
      col_p1_d  = seg_idx(dx_p0);
      row_p1_d  = seg_idx(dy_p0);
      offx_p1_d = seg_off(dx_p0, col_p1_d);
      offy_p1_d = seg_off(dy_p0, row_p1_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inb_p1_q  <= 1'b0;
      col_p1_q  <= '0;
      row_p1_q  <= '0;
      offx_p1_q <= '0;
      offy_p1_q <= '0;
      vld_p1_q  <= 1'b0;
    end else begin
      inb_p1_q  <= inb_p1_d;
      col_p1_q  <= col_p1_d;
      row_p1_q  <= row_p1_d;
      offx_p1_q <= offx_p1_d;
      offy_p1_q <= offy_p1_d;
      vld_p1_q  <= pix_valid_i;
    end
  end

`ifdef CURSOR_HILITE_EN
  logic [3:0] cur_p1_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cur_p1_q <= '0;
    else
      cur_p1_q <= cursor_cell_i;
  end
`endif

  assign cell_p1   = ({2'b00, row_p1_q} * 4'd3) + {2'b00, col_p1_q};
  assign rom_sel_o = inb_p1_q ? cell_code(board_q, cell_p1) : SEL_NONE;
  assign rom_row_o = offy_p1_q;

  // ---------------------------------------------------------------- stage 2: pixel bit
  logic [6:0] bit_idx_p1;
  logic       rom_bit_p1;
  logic       hl_p1;
  logic       pix_on_p2_q;
  logic       vld_p2_q;

  assign bit_idx_p1 = 7'd79 - offx_p1_q;
  assign rom_bit_p1 = rom_data_i[bit_idx_p1];
`ifdef CURSOR_HILITE_EN
  assign hl_p1 = (cur_p1_q <= 4'd8) && (cur_p1_q == cell_p1);
`else
  assign hl_p1 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_on_p2_q <= 1'b0;
      vld_p2_q    <= 1'b0;
    end else begin
      pix_on_p2_q <= inb_p1_q && (rom_bit_p1 ^ hl_p1);
      vld_p2_q    <= vld_p1_q;
    end
  end

  assign pix_on_o        = pix_on_p2_q;
  assign pix_out_valid_o = vld_p2_q;

endmodule

// File: tb/tb_board_render_ctrl.sv
// Directed bench for board_render_ctrl: per-cycle comparison against a behavioural model
// plus literal expectations at the points of interest.
module tb_board_render_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  px, py;
  logic        pv, fs, clr, mvv;
  logic [3:0]  mvc, cur;
  logic [1:0]  rom_sel;
  logic [6:0]  rom_row;
  logic [79:0] rom_data;
  logic        pix_on, pix_out_valid, turn;
  logic [17:0] board;
  logic        run;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  board_render_ctrl_if mvif ();
  assign mvif.mv_valid = mvv;
  assign mvif.mv_cell  = mvc;

  board_render_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pix_x_i         (px),
    .pix_y_i         (py),
    .pix_valid_i     (pv),
    .frame_start_i   (fs),
    .game_clr_i      (clr),
    .mv              (mvif.slave),
    .rom_sel_o       (rom_sel),
    .rom_row_o       (rom_row),
    .rom_data_i      (rom_data),
    .pix_on_o        (pix_on),
    .pix_out_valid_o (pix_out_valid),
    .turn_o          (turn),
    .board_o         (board)
`ifdef CURSOR_HILITE_EN
    ,
    .cursor_cell_i   (cur)
`endif
  );

  // Shape ROMs: grid border, X diagonals, O square ring.
  function automatic logic rom_bit(input logic [1:0] sel, input int row, input int col);
    case (sel)
      2'b00:   return row == 0 || row == 79 || col == 0 || col == 79;
      2'b01:   return col == row || col == 79 - row;
      2'b10:   return ((row == 20 || row == 59) && col >= 20 && col <= 59) ||
                      ((col == 20 || col == 59) && row >= 20 && row <= 59);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    rom_data = '0;
    for (int c = 0; c < 80; c++)
      rom_data[79 - c] = rom_bit(rom_sel, int'(rom_row), c);
  end

  // ---------------- behavioural model
  logic [1:0] m_board [0:8];
  logic       m_turn, m_pend, m_commit, m_err;
  int         m_pc;
  logic       m_inb, m_vld, m_pov, m_pon;
  int         m_cell, m_offx, m_offy, m_cur;
  logic       m_hl;

  function automatic logic in_board(input logic [9:0] x, input logic [9:0] y, input logic v);
    return v && int'(x) >= 200 && int'(x) < 440 && int'(y) >= 120 && int'(y) < 360;
  endfunction

  function automatic logic [17:0] mpack();
    logic [17:0] r;
    for (int n = 0; n < 9; n++)
      r[2*n +: 2] = m_board[n];
    return r;
  endfunction

`ifdef CURSOR_HILITE_EN
  assign m_hl = (m_cur < 9) && (m_cur == m_cell);
`else
  assign m_hl = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 9; n++) m_board[n] <= 2'b00;
      m_turn <= 0; m_pend <= 0; m_commit <= 0; m_err <= 0; m_pc <= 0;
      m_inb <= 0; m_vld <= 0; m_pov <= 0; m_pon <= 0;
      m_cell <= 0; m_offx <= 0; m_offy <= 0; m_cur <= 0;
    end else begin
      m_inb  <= in_board(px, py, pv);
      m_cell <= in_board(px, py, pv) ? ((int'(py) - 120) / 80) * 3 + (int'(px) - 200) / 80 : 0;
      m_offx <= in_board(px, py, pv) ? (int'(px) - 200) % 80 : 0;
      m_offy <= in_board(px, py, pv) ? (int'(py) - 120) % 80 : 0;
      m_cur  <= int'(cur);
      m_vld  <= pv;
      m_pov  <= m_vld;
      m_pon  <= m_inb ? (rom_bit(m_board[m_cell], m_offy, m_offx) ^ m_hl) : 1'b0;
      m_err  <= 1'b0;
      if (fs && clr) begin
        for (int n = 0; n < 9; n++) m_board[n] <= 2'b00;
        m_turn <= 0; m_pend <= 0; m_commit <= 0;
      end else if (m_commit) begin
        m_board[m_pc] <= m_turn ? 2'b10 : 2'b01;
        m_turn <= ~m_turn;
        m_commit <= 0;
      end else if (m_pend) begin
        if (fs) begin m_pend <= 0; m_commit <= 1; end
      end else if (mvv) begin
        if (mvc > 8 || m_board[(mvc > 8) ? 0 : int'(mvc)] != 2'b00)
          m_err <= 1'b1;
        else begin
          m_pend <= 1'b1;
          m_pc <= int'(mvc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("board", 32'(board), 32'(mpack()));
      chk("turn", 32'(turn), 32'(m_turn));
      chk("mv_ready", 32'(mvif.mv_ready), 32'(!m_pend && !m_commit));
      chk("mv_err", 32'(mvif.mv_err), 32'(m_err));
      chk("rom_sel", 32'(rom_sel), m_inb ? 32'(m_board[m_cell]) : 32'd3);
      if (m_inb) chk("rom_row", 32'(rom_row), 32'(m_offy));
      chk("pix_out_valid", 32'(pix_out_valid), 32'(m_pov));
      chk("pix_on", 32'(pix_on), 32'(m_pon));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; px = 0; py = 0; pv = 0; fs = 0; clr = 0; mvv = 0; mvc = 0; cur = 4'd15; run = 1;
    repeat (3) cyc();
    chk("rst_rom_sel", 32'(rom_sel), 32'd3);
    chk("rst_ready", 32'(mvif.mv_ready), 32'd1);
    chk("rst_board", 32'(board), 32'd0);
    chk("rst_pix_on", 32'(pix_on), 32'd0);
    rst_n = 1;
    cyc();

    px = 246; py = 121; pv = 1; cyc();
    chk("lat_sel", 32'(rom_sel), 32'd0);
    chk("lat_row", 32'(rom_row), 32'd1);
    pv = 0; px = 0; py = 0; cyc();
    chk("lat_pix_on", 32'(pix_on), 32'd0);
    chk("lat_pov", 32'(pix_out_valid), 32'd1);
    px = 200; py = 120; pv = 1; cyc(); pv = 0; cyc();
    chk("corner_pix_on", 32'(pix_on), 32'd1);
    px = 100; py = 121; pv = 1; cyc();
    chk("outside_sel", 32'(rom_sel), 32'd3);
    pv = 0; cyc();
    chk("outside_pix_on", 32'(pix_on), 32'd0);
    for (int i = 0; i < 60; i++) begin
      px = 10'(190 + i * 5); py = 10'(115 + i * 4); pv = 1; cyc();
    end
    pv = 0;

    mvv = 1; mvc = 4; cyc(); mvv = 0;
    chk("pend_ready", 32'(mvif.mv_ready), 32'd0);
    repeat (50) cyc();
    chk("pre_commit_board", 32'(board), 32'd0);
    fs = 1; cyc(); fs = 0; cyc();
    chk("commit_board", 32'(board), 32'h100);
    chk("commit_turn", 32'(turn), 32'd1);
    chk("commit_ready", 32'(mvif.mv_ready), 32'd1);
    px = 320; py = 240; pv = 1; cyc();
    chk("x_sel", 32'(rom_sel), 32'd1);
    chk("x_row", 32'(rom_row), 32'd40);
    pv = 0; cyc();
    chk("x_pix_on", 32'(pix_on), 32'd1);

    mvv = 1; mvc = 4; cyc(); mvv = 0;
    chk("dup_err", 32'(mvif.mv_err), 32'd1);
    cyc();
    chk("dup_err_end", 32'(mvif.mv_err), 32'd0);
    chk("dup_board", 32'(board), 32'h100);
    mvv = 1; mvc = 9; cyc(); mvv = 0;
    chk("range_err", 32'(mvif.mv_err), 32'd1);
    cyc();

    mvv = 1; mvc = 2; cyc(); mvc = 5;
    chk("blocked_ready", 32'(mvif.mv_ready), 32'd0);
    cyc(); cyc(); mvv = 0;
    chk("blocked_err", 32'(mvif.mv_err), 32'd0);
    fs = 1; cyc(); fs = 0; cyc();
    chk("o_board", 32'(board), 32'h120);
    chk("o_turn", 32'(turn), 32'd0);

    mvv = 1; mvc = 6; fs = 1; cyc(); mvv = 0; fs = 0;
    chk("simul_ready", 32'(mvif.mv_ready), 32'd0);
    repeat (5) cyc();
    chk("simul_hold", 32'(board), 32'h120);
    fs = 1; cyc(); fs = 0; cyc();
    chk("simul_board", 32'(board), 32'h1120);

    mvv = 1; mvc = 0; cyc(); mvv = 0;
    repeat (3) cyc();
    clr = 1; fs = 1; cyc(); clr = 0; fs = 0;
    chk("clr_board", 32'(board), 32'd0);
    chk("clr_turn", 32'(turn), 32'd0);
    chk("clr_ready", 32'(mvif.mv_ready), 32'd1);
    chk("clr_err", 32'(mvif.mv_err), 32'd0);
    cyc();

    mvv = 1; mvc = 8; cyc(); mvv = 0; fs = 1; cyc(); fs = 0; cyc();
    chk("pre_rst_board", 32'(board), 32'h10000);
    mvv = 1; mvc = 3; cyc(); mvv = 0;
    px = 300; py = 200; pv = 1; cyc();
    #2 rst_n = 0;
    #1;
    chk("async_board", 32'(board), 32'd0);
    chk("async_turn", 32'(turn), 32'd0);
    chk("async_ready", 32'(mvif.mv_ready), 32'd1);
    chk("async_pix_on", 32'(pix_on), 32'd0);
    chk("async_sel", 32'(rom_sel), 32'd3);
    pv = 0; cyc(); cyc();
    rst_n = 1; cyc();

`ifdef CURSOR_HILITE_EN
    cur = 0; px = 200; py = 120; pv = 1; cyc(); pv = 0; cyc();
    chk("hl_on", 32'(pix_on), 32'd0);
    cur = 15; pv = 1; cyc(); pv = 0; cyc();
    chk("hl_off", 32'(pix_on), 32'd1);
`endif

    repeat (3) cyc();
    run = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
